mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 2, RAM beats per data grant (one cache block).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, cycles a grant may wait for ACCESS before forced release.
REQ-003 CLK  in  1  clock; nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  2  per-core instruction read request; iaddr  in  2x32  per-core instruction address.
REQ-005 dREN, dWEN  in  2 each  per-core data read/write request; daddr, dstore  in  2x32  per-core data address and write data.
REQ-006 ramstate  in  2  ramstate_t from the RAM (FREE, BUSY, ACCESS, ERROR); ramload  in  32  RAM read data.
REQ-007 ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each  single RAM port.
REQ-008 iwait, dwait  out  2 each  per-core stall; iload, dload  out  2x32  per-core read data.
REQ-009 gnt  out  2  one-hot granted core; gnt_d  out  1  grant is data (1) or instruction (0); err  out  2  per-core one-cycle error/timeout pulse.

Function
REQ-010 States: IDLE, GRANT_I, GRANT_D; state, beat counter, timeout counter, round-robin pointer rr are registered.
REQ-011 IDLE with any request: select core rr if it has a request, else the other core; within a core, data beats instruction; next state GRANT_D or GRANT_I; one-cycle arbitration latency.
REQ-012 dWEN and dREN both high on a core: treated as write.
REQ-013 In GRANT_*: ramaddr/ramstore/ramREN/ramWEN are combinational copies of the grantee's address, data and enable; all other requesters see wait=1.
REQ-014 Grantee's wait is 0 only in a cycle with ramstate==ACCESS; that cycle iload/dload of grantee equals ramload; loads of non-grantees are 0.
REQ-015 Each ACCESS cycle increments beat counter; GRANT_I ends after 1 beat, GRANT_D after BLOCK_WORDS beats; grantee updates daddr between beats.
REQ-016 Grant end: next state IDLE (one bubble), rr set to the other core, beat and timeout counters cleared.
REQ-017 Grantee drops its request mid-grant: next state IDLE, counters cleared, rr unchanged, no RAM enable that cycle.
REQ-018 ramstate==ERROR during grant: grantee wait stays 1, err[grantee] pulses, grant released as in REQ-016.
REQ-019 Simultaneous requests from both cores in IDLE: rr decides; a waiting core is granted within one grant of the other (no starvation).
REQ-020 No grant: ramREN=ramWEN=0, ramaddr=ramstore=0, gnt=0, all waits 1 for asserted requests, 0 otherwise.

Reset
REQ-021 nRST low: state IDLE, rr=0 (core 0 first), counters 0, all RAM enables 0, gnt=0, err=0, takes effect immediately mid-grant.

Configuration
REQ-022 MEM_ARB_TIMEOUT_EN defined: timeout counter counts non-ACCESS grant cycles; reaching TIMEOUT_CYCLES pulses err[grantee] and releases grant as REQ-016.
REQ-023 MEM_ARB_TIMEOUT_EN undefined: no timeout counter; a grant holds until completion, drop, or ERROR.

Structure
REQ-024 ramstate_t, word_t and the arbiter state enum live in cpu_types_pkg; BLOCK_WORDS default mirrors the package block-size constant.
REQ-025 One sub-module rr_picker: combinational 2-core round-robin select (request vectors, rr in; core and d/i choice out).

Verification
REQ-026 Core0 dREN, daddr 0x100, RAM ACCESS on 2nd cycle of each beat -> 2 ACCESS beats, dwait[0] low exactly twice, dload[0]=ramload, then IDLE, rr=1.
REQ-027 Both cores iREN, rr=0 -> core0 granted first, core1 granted after one IDLE bubble, iwait[1] high throughout core0 grant.
REQ-028 Core1 iREN and dWEN daddr 0x200 dstore 0xDEADBEEF -> data first: ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF; instruction after.
REQ-029 ramstate ERROR during GRANT_D -> err pulse one cycle for grantee, dwait stays 1, return to IDLE.
REQ-030 With MEM_ARB_TIMEOUT_EN, ramstate held BUSY 64 cycles -> err pulse, release; without macro -> grant held indefinitely.
REQ-031 nRST asserted mid-GRANT_D after beat 1 -> outputs reset immediately; after release, rr=0 and fresh 2-beat grant.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, data word and memory
// arbiter FSM states, plus the cache block size used by the arbiter.
package cpu_types_pkg;

    // Words per cache block; the arbiter's data-grant length defaults to this.
    localparam int BLOCK_WORDS_DEF = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational two-core round-robin selector. The core pointed to by rr
// wins if it has any request; otherwise the other core is chosen. Within the
// chosen core a data request takes priority over an instruction fetch.
module rr_picker (
    input  logic [1:0] ireq,
    input  logic [1:0] dreq,
    input  logic       rr,
    output logic       any,
    output logic       core,
    output logic       is_d
);
    logic [1:0] req;

    assign req  = ireq | dreq;
    assign any  = |req;
    assign core = req[rr] ? rr : ~rr;
    assign is_d = dreq[core];

endmodule

// File: rtl/mem_arbiter.sv
// Two-core memory arbiter sharing one RAM port between per-core instruction
// and data requests. A data grant lasts one cache block (BLOCK_WORDS beats),
// an instruction grant one beat; every grant is followed by an IDLE bubble.
// Optional: define MEM_ARB_TIMEOUT_EN to release a grant that has seen
// TIMEOUT_CYCLES non-ACCESS cycles, flagging err for the stalled core.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BLOCK_WORDS    = BLOCK_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  ramstate_t        ramstate,
    input  logic [31:0]      ramload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    output logic [1:0]       iwait,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] iload,
    output logic [1:0][31:0] dload,
    output logic [1:0]       gnt,
    output logic             gnt_d,
    output logic [1:0]       err
);
    localparam int BW = $clog2(BLOCK_WORDS + 1);

    arb_state_t    state, nxt_state;
    logic          cur, nxt_cur;
    logic          rr, nxt_rr;
    logic [BW-1:0] beat, nxt_beat, beat_inc;

    logic [1:0] dreq;
    logic       pick_any, pick_core, pick_d;
    logic       granted, active, hit, fault, done, tmo, rel, flip;

    // A write-and-read on the same core counts as one data request (a write).
    assign dreq = dREN | dWEN;

    rr_picker u_pick (
        .ireq (iREN),
        .dreq (dreq),
        .rr   (rr),
        .any  (pick_any),
        .core (pick_core),
        .is_d (pick_d)
    );

    assign granted  = (state != IDLE);
    assign active   = granted & ((state == GRANT_D) ? dreq[cur] : iREN[cur]);
    assign hit      = active & (ramstate == ACCESS);
    assign fault    = active & (ramstate == ERROR);
    assign beat_inc = beat + BW'(1);
    assign done     = hit & (beat_inc == ((state == GRANT_D) ? BW'(BLOCK_WORDS) : BW'(1)));
    // A dropped request releases without moving rr; any other release hands
    // priority to the other core so neither can starve.
    assign rel      = granted & (~active | done | fault | tmo);
    assign flip     = active & (done | fault | tmo);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign tmo = active & ~hit & ~fault & (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Count non-ACCESS cycles across the whole grant; cleared on release.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            tcnt <= '0;
        else if (!granted || rel)
            tcnt <= '0;
        else if (!hit)
            tcnt <= tcnt + TW'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    // State, grantee, round-robin pointer and beat counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cur   <= 1'b0;
            rr    <= 1'b0;
            beat  <= '0;
        end else begin
            state <= nxt_state;
            cur   <= nxt_cur;
            rr    <= nxt_rr;
            beat  <= nxt_beat;
        end
    end

    // Next-state: arbitrate from IDLE, count beats, release on done/drop/fault.
    always_comb begin
        nxt_state = state;
        nxt_cur   = cur;
        nxt_rr    = rr;
        nxt_beat  = beat;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    nxt_state = pick_d ? GRANT_D : GRANT_I;
                    nxt_cur   = pick_core;
                    nxt_beat  = '0;
                end
            end
            default: begin
                if (rel) begin
                    nxt_state = IDLE;
                    nxt_beat  = '0;
                    if (flip)
                        nxt_rr = ~cur;
                end else if (hit) begin
                    nxt_beat = beat_inc;
                end
            end
        endcase
    end

    // Outputs: steer the grantee onto the RAM port, stall everyone else.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        gnt      = '0;
        gnt_d    = 1'b0;
        err      = '0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        case (state)
            GRANT_I: begin
                ramREN   = iREN[cur];
                ramaddr  = iaddr[cur];
                gnt[cur] = 1'b1;
                if (hit) begin
                    iwait[cur] = 1'b0;
                    iload[cur] = ramload;
                end
            end
            GRANT_D: begin
                ramWEN   = dWEN[cur];
                ramREN   = dREN[cur] & ~dWEN[cur];
                ramaddr  = daddr[cur];
                ramstore = dstore[cur];
                gnt[cur] = 1'b1;
                gnt_d    = 1'b1;
                if (hit) begin
                    dwait[cur] = 1'b0;
                    dload[cur] = ramload;
                end
            end
            default: ;
        endcase
        if (fault | tmo)
            err[cur] = 1'b1;
    end

endmodule
